// File: rtl/wb_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_host_pkg
// Description : Shared types and bus widths for the Wishbone host master.
//               Holds the two-state controller encoding and the address,
//               data and byte-select widths of the Wishbone port.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_host_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // IDLE: command port open, bus quiet. BUS: one transfer outstanding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } wb_state_e;

endpackage : wb_host_pkg
`default_nettype wire

// File: rtl/wb_host_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_host_timeout
// Description : 16-bit bus-cycle watchdog for the Wishbone host master.
//               Counts enabled cycles since the last clear and flags the
//               edge at which the count reaches the configured limit.
// Revision    : 1.0 - initial release
//
// Ports
//   wb_clk_i    in   1   clock, rising edge
//   wb_rst_n_i  in   1   asynchronous active-low reset
//   clear_i     in   1   restart the count from zero at the next edge
//   enable_i    in   1   a bus cycle elapsed without acknowledge
//   limit_i     in  16   number of unacknowledged cycles allowed
//   expired_o   out  1   this edge is the one at which the limit is reached
// ============================================================================
module wb_host_timeout (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [16:0] w_count_next;

    // Count as it will stand after this edge; compared one bit wider so a
    // limit of 65535 does not wrap.
    assign w_count_next = {1'b0, count_q} + 17'd1;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = w_count_next[15:0];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (w_count_next == {1'b0, limit_i});

endmodule : wb_host_timeout
`default_nettype wire

// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_host_master
// Description : Single-outstanding Wishbone classic master driven by a
//               valid/ready command port, returning a one-cycle response
//               pulse with read data and an error (timeout) flag.
// Revision    : 1.0 - initial release
//
// Configuration macro
//   WB_HOST_TIMEOUT_EN : when defined, a transfer with no acknowledge for
//                        TIMEOUT_CYCLES bus cycles is aborted with
//                        rsp_err_o=1. When undefined the bus waits forever.
//
// Ports
//   wb_clk_i, wb_rst_n_i          clock, async active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i          command fields
//   rsp_valid_o, rsp_dat_o,
//   rsp_err_o                     completion pulse, read data, timeout flag
//   busy_o                        transfer outstanding
//   wbm_*                         Wishbone classic master port
// ============================================================================
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
);

    if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_host_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    wb_state_e           state_q,     state_d;
    logic [WB_ADR_W-1:0] adr_q,       adr_d;
    logic [WB_DAT_W-1:0] dat_q,       dat_d;
    logic [WB_SEL_W-1:0] sel_q,       sel_d;
    logic                we_q,        we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic                rsp_err_q,   rsp_err_d;

    logic w_in_bus;
    logic w_handshake;
    logic w_expired;

    assign w_in_bus    = (state_q == BUS);
    assign w_handshake = cmd_valid_i && !w_in_bus;

`ifdef WB_HOST_TIMEOUT_EN
    // Enable excludes acknowledged cycles, so an ack on the expiry edge
    // suppresses the timeout and completes normally.
    wb_host_timeout u_timeout (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .clear_i    (w_handshake),
        .enable_i   (w_in_bus && !wbm_ack_i),
        .limit_i    (16'(TIMEOUT_CYCLES)),
        .expired_o  (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (w_handshake) begin
                    state_d = BUS;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    we_d    = cmd_we_i;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                end else if (w_expired) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Bus strobes decode straight from the state so reset drops them at once.
    assign cmd_ready_o = !w_in_bus;
    assign busy_o      = w_in_bus;
    assign wbm_cyc_o   = w_in_bus;
    assign wbm_stb_o   = w_in_bus;
    assign wbm_we_o    = w_in_bus && we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule : wb_host_master
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_host_master
// Description : Self-checking bench for wb_host_master. Directed scenarios
//               followed by randomized transfers; expected responses come
//               from a transaction-level model of the command/response rules.
//               Timeout scenarios are compiled in with WB_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_host_master;

    localparam int TO = 4;
`ifdef WB_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        cyc;
    logic        stb;
    logic        wbm_we;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat;
    logic [3:0]  wbm_sel;
    logic        ack;
    logic [31:0] ack_dat;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: response fields hold until the next completion.
    logic [31:0] m_rsp_dat = '0;
    logic        m_rsp_err = 1'b0;

    always #5 clk = ~clk;

    wb_host_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (wbm_we),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat),
        .wbm_sel_o   (wbm_sel),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (ack_dat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer: handshake, d-th bus cycle carries the ack.
    // With the watchdog on and d beyond the limit, no ack is given and the
    // transfer must abort after TO bus cycles.
    task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int d, input logic [31:0] rd);
        bit timeout;
        int ncyc;
        timeout = TO_EN && (d > TO);
        ncyc    = timeout ? TO : d;

        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        check("ready_before", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
        cmd_we    = ~we;
        for (int k = 1; k <= ncyc; k++) begin
            check("bus_ctrl", 32'({cyc, stb, busy, cmd_ready, rsp_valid}), 32'b11100);
            check("bus_we", 32'(wbm_we), 32'(we));
            check("bus_adr", wbm_adr, adr);
            check("bus_dat", wbm_dat, dat);
            check("bus_sel", 32'(wbm_sel), 32'(sel));
            if (k == d) begin
                ack     = 1'b1;
                ack_dat = rd;
            end else begin
                ack     = 1'b0;
                ack_dat = $urandom;
            end
            step();
        end
        ack     = 1'b0;
        ack_dat = $urandom;

        m_rsp_err = timeout;
        m_rsp_dat = (timeout || we) ? 32'd0 : rd;
        check("done_ctrl", 32'({cyc, stb, wbm_we, busy, cmd_ready, rsp_valid}), 32'b000011);
        check("done_dat", rsp_dat, m_rsp_dat);
        check("done_err", 32'(rsp_err), 32'(m_rsp_err));
        check("done_adr_hold", wbm_adr, adr);
    endtask

    // Idle cycles after a completion; optional stray acks must be ignored.
    task automatic idle(input int n, input bit stray);
        for (int k = 0; k < n; k++) begin
            ack     = stray ? 1'($urandom) : 1'b0;
            ack_dat = $urandom;
            step();
            check("idle_ctrl", 32'({cyc, stb, busy, cmd_ready, rsp_valid}), 32'b00010);
            check("idle_dat_hold", rsp_dat, m_rsp_dat);
            check("idle_err_hold", 32'(rsp_err), 32'(m_rsp_err));
        end
        ack = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        ack       = 1'b0;
        ack_dat   = '0;

        // Reset state
        repeat (2) step();
        check("rst_ctrl", 32'({cyc, stb, wbm_we, rsp_valid, rsp_err, busy}), 32'd0);
        check("rst_adr", wbm_adr, 32'd0);
        check("rst_dat", wbm_dat, 32'd0);
        check("rst_sel", 32'(wbm_sel), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write with ack on third bus cycle
        do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 3, 32'h5555_AAAA);
        idle(1, 1'b0);

        // Read, ack on first bus cycle: two-cycle latency
        do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h1234_5678);
        idle(1, 1'b0);

        // Back-to-back reads with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0010;
        cmd_sel   = 4'h3;
        step();
        check("b2b_a_bus", 32'({stb, wbm_adr == 32'h3000_0010}), 32'b11);
        ack       = 1'b1;
        ack_dat   = 32'hA5A5_0001;
        cmd_adr   = 32'h3000_0020;
        cmd_sel   = 4'hC;
        step();
        m_rsp_dat = 32'hA5A5_0001;
        m_rsp_err = 1'b0;
        check("b2b_gap", 32'({stb, cmd_ready, rsp_valid}), 32'b011);
        check("b2b_a_dat", rsp_dat, m_rsp_dat);
        ack = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("b2b_b_bus", 32'({stb, rsp_valid, busy}), 32'b101);
        check("b2b_b_adr", wbm_adr, 32'h3000_0020);
        check("b2b_b_sel", 32'(wbm_sel), 32'hC);
        ack     = 1'b1;
        ack_dat = 32'hA5A5_0002;
        step();
        ack       = 1'b0;
        m_rsp_dat = 32'hA5A5_0002;
        check("b2b_b_done", 32'({stb, rsp_valid}), 32'b01);
        check("b2b_b_dat", rsp_dat, m_rsp_dat);
        idle(1, 1'b0);

        // Watchdog: no ack aborts (or waits); ack on the expiry edge wins
        do_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, TO + 3, 32'hFFFF_0000);
        idle(1, 1'b0);
        do_txn(1'b0, 32'h4000_0004, 32'h0, 4'hF, TO, 32'h0BAD_F00D);
        idle(1, 1'b0);
        do_txn(1'b1, 32'h4000_0008, 32'h1111_2222, 4'h1, TO + 1, 32'h0);
        idle(1, 1'b0);

        // Reset in bus cycle 2: strobes drop immediately, no response
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h5000_0000;
        cmd_dat   = 32'h7777_7777;
        cmd_sel   = 4'hF;
        step();
        cmd_valid = 1'b0;
        step();
        check("pre_rst_bus", 32'({cyc, stb, busy}), 32'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", 32'({cyc, stb, wbm_we, busy, rsp_valid}), 32'd0);
        check("async_rst_adr", wbm_adr, 32'd0);
        check("async_rst_rsp_dat", rsp_dat, 32'd0);
        step();
        rst_n     = 1'b1;
        m_rsp_dat = 32'd0;
        m_rsp_err = 1'b0;
        check("ready_after_abort", 32'(cmd_ready), 32'd1);
        idle(4, 1'b1);

        // Randomized transfers against the model
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(1, TO + 2)), $urandom);
            idle(int'($urandom_range(1, 3)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_wb_host_master
`default_nettype wire

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving bus cycles without ack before abort (valid range 1..65535).
REQ-002 wb_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when both valid and ready are high at a clock edge.
REQ-006 cmd_we_i  input  1  1 means write, 0 means read.
REQ-007 cmd_adr_i / cmd_dat_i / cmd_sel_i  input  32/32/4  address, write data, byte selects.
REQ-008 rsp_valid_o  output  1  one-cycle completion pulse; no backpressure.
REQ-009 rsp_dat_o / rsp_err_o  output  32/1  read data, timeout flag.
REQ-010 busy_o  output  1  high while a transaction is outstanding.
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-012 wbm_adr_o / wbm_dat_o / wbm_sel_o  output  32/32/4  Wishbone address, write data, selects.
REQ-013 wbm_ack_i / wbm_dat_i  input  1/32  responder ack and read data.

Function
REQ-014 FSM SHALL have exactly two states: IDLE and BUS.
REQ-015 cmd_ready_o SHALL be high only in IDLE; a handshake in IDLE moves to BUS at that edge.
REQ-016 On handshake, adr/dat/sel/we SHALL be registered; cyc_o=stb_o=1 from the next cycle, all held stable until completion.
REQ-017 In BUS, ack sampled high at an edge SHALL complete: next cycle cyc_o=stb_o=0, state IDLE, rsp_valid_o=1 for exactly one cycle, rsp_err_o=0.
REQ-018 Read completion SHALL capture wbm_dat_i at the ack edge into rsp_dat_o; write completion SHALL set rsp_dat_o=0.
REQ-019 rsp_dat_o/rsp_err_o SHALL hold until the next completion.
REQ-020 Minimum latency: handshake at edge N, ack at edge N+1, rsp_valid_o high in cycle after N+1 (one-cycle bus phase).
REQ-021 A new command MAY be accepted in the cycle rsp_valid_o is high (back-to-back, one idle bus cycle between strobes).
REQ-022 busy_o SHALL equal (state==BUS).
REQ-023 wbm_ack_i outside BUS SHALL be ignored.
REQ-024 wbm_dat_o/wbm_adr_o/wbm_sel_o SHALL retain last values in IDLE; wbm_we_o SHALL be 0 in IDLE.

Reset
REQ-025 Assertion of wb_rst_n_i SHALL immediately force IDLE, cyc/stb/we/rsp_valid/rsp_err/busy=0, adr/dat/sel/rsp_dat=0, timeout count=0, cmd_ready_o=1 after release.
REQ-026 Reset mid-transaction SHALL abort with no rsp_valid_o pulse.

Configuration
REQ-027 With WB_HOST_TIMEOUT_EN defined: a 16-bit counter clears on entering BUS, increments each BUS cycle without ack; when it reaches TIMEOUT_CYCLES the transaction SHALL abort as REQ-017 but with rsp_err_o=1, rsp_dat_o=0.
REQ-028 Ack at the same edge as timeout expiry SHALL win (normal completion, rsp_err_o=0).
REQ-029 Without WB_HOST_TIMEOUT_EN: no counter is built, BUS waits indefinitely, rsp_err_o tied 0.

Structure
REQ-030 Shared package wb_host_pkg SHALL hold the state enum (IDLE, BUS), WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
REQ-031 Timeout counter SHALL be sub-module wb_host_timeout (clear, enable, limit in; expired out), instantiated only under WB_HOST_TIMEOUT_EN.

Verification
REQ-032 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, ack after 3 cycles -> cyc/stb high 3 cycles, we=1, fields stable, one rsp_valid, rsp_err=0, rsp_dat=0.
REQ-033 Read adr=0x3000_0000, ack next cycle with dat_i=0x1234_5678 -> rsp_dat=0x1234_5678, total latency 2 cycles from handshake.
REQ-034 Back-to-back reads with cmd_valid held high -> second handshake during first rsp_valid cycle, stb low exactly one cycle between transactions.
REQ-035 (TIMEOUT_EN, TIMEOUT_CYCLES=4) no ack -> abort after 4 bus cycles, rsp_err=1, rsp_dat=0; ack on expiry edge -> rsp_err=0.
REQ-036 Reset asserted in BUS cycle 2 -> cyc/stb drop asynchronously, no rsp_valid, cmd_ready=1 after release; stray ack in IDLE -> no response.
